dither_ctrl: RTL and testbench
==============================

DITHER_CTRL -- requirements
Module: dither_ctrl

Interface
REQ-001 Parameter DW, default 16: sample width in bits, signed two's complement.
REQ-002 Parameter RAMP_LEN, default 16: accepted samples per gain step, legal range 1..255.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset: asynchronous, active-low.
REQ-005 cfg_en  input  1  dither enable request; level-sensitive.
REQ-006 cfg_shift  input  2  dither amplitude left-shift, 0..3.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  DW  upstream signed sample.
REQ-010 dith_in  input  2  signed dither from the sequence generator; legal values +1 (2'b01) and -1 (2'b11).
REQ-011 dith_adv  output  1  one-cycle clock-enable that advances the dither generator.
REQ-012 out_valid  output  1  output sample valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_data  output  DW  dithered, saturated signed sample.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN.
REQ-016 gain  output  4  current dither gain, 0..8.
REQ-017 sat_flag  output  1  sticky saturation indicator.

Function
REQ-018 A sample is accepted ("accept") in a cycle where in_valid=1 and in_ready=1.
REQ-019 in_ready = !out_valid || out_ready; this is combinational, and the single output register gives 1-cycle latency.
REQ-020 On accept, out_data and out_valid=1 are registered next edge; out_valid clears on out_valid&&out_ready with no accept.
REQ-021 Simultaneous output drain and accept: out_valid stays 1 and out_data is replaced, with no bubble.
REQ-022 While out_valid=1 and out_ready=0, out_data is held stable.
REQ-023 dith_adv = accept (combinational), exactly one pulse per accepted sample, in every state including IDLE.
REQ-024 dith_in and cfg_shift are sampled in the accept cycle.
REQ-025 Dither term d = dith_in * gain << cfg_shift, signed, at least 8 bits wide; |d| <= 64.
REQ-026 out_data = in_data + d, computed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-027 When saturation occurs on an accept, sat_flag is set on the next edge; sat_flag is cleared only by reset.
REQ-028 A sample counter scnt (8 bits) increments on each accept in RAMP_UP and RAMP_DOWN; when scnt reaches RAMP_LEN-1 on an accept, the gain steps and scnt returns to 0.
REQ-029 IDLE: gain=0; cfg_en=1 -> RAMP_UP next edge, with scnt=0.
REQ-030 RAMP_UP: gain += 1 per step; the step that makes gain=8 moves the FSM to ACTIVE on the same edge.
REQ-031 RAMP_UP with cfg_en=0 -> RAMP_DOWN next edge; scnt clears and gain holds.
REQ-032 ACTIVE: gain=8; cfg_en=0 -> RAMP_DOWN next edge, with scnt=0.
REQ-033 RAMP_DOWN: gain -= 1 per step; the step that makes gain=0 moves the FSM to IDLE on the same edge.
REQ-034 RAMP_DOWN with cfg_en=1 -> RAMP_UP next edge; scnt clears and gain holds.
REQ-035 The ramp advances only on accepts; with no accepts, gain and scnt hold indefinitely.
REQ-036 On an edge carrying both an accept and a gain step, that accepted sample uses the pre-step gain.

Reset
REQ-037 rstn=0 immediately forces: state=IDLE, gain=0, scnt=0, out_valid=0, out_data=0, sat_flag=0.
REQ-038 While rstn=0, in_ready=1 and dith_adv=0.
REQ-039 Reset asserted mid-ramp or mid-transfer discards any pending output sample; after release the block starts from IDLE.

Verification
REQ-040 Bench covers: cfg_en=0, in_data=100, dith_in=+1, continuous handshake -> out_data=100 every sample, one dith_adv per accept, 1-cycle latency.
REQ-041 Bench covers: cfg_en=1, RAMP_LEN=16, shift=0 -> gain reaches 8 after exactly 128 accepts, state=ACTIVE; with in_data=0 and dith_in=-1, out_data=-8.
REQ-042 Bench covers: ACTIVE, shift=3, in_data=32760, dith_in=+1 -> out_data=32767, sat_flag=1; in_data=-32768, dith_in=-1 -> out_data=-32768.
REQ-043 Bench covers: cfg_en dropped at gain=5 in RAMP_UP -> RAMP_DOWN with gain held at 5, then IDLE after 80 accepts, and no gain change while in_valid=0.
REQ-044 Bench covers: out_ready=0 for 10 cycles -> in_ready=0, out_data stable, no dith_adv pulses; release -> no sample lost or duplicated.
REQ-045 Bench covers: rstn pulsed low in ACTIVE with out_valid=1 -> all outputs at reset values immediately, out_valid=0, state=IDLE.

Source files
------------

// File: rtl/dither_if.sv
// Sample-stream handshake bundle for dither_ctrl: upstream sample, dither
// generator hookup and downstream output register.
interface dither_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    dith_in;
  logic          dith_adv;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, dith_in, out_ready,
    input  in_ready, dith_adv, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, dith_in, out_ready,
    output in_ready, dith_adv, out_valid, out_data
  );
endinterface

// File: rtl/dither_ctrl.sv
// Adds a gain-ramped +/-1 dither to a signed sample stream through a single
// saturating output register; the gain ramps 0..8 one step per RAMP_LEN accepts.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | dither off, gain=0, waiting for cfg_en
//   RAMP_UP   | gain climbs one step per RAMP_LEN accepted samples
//   ACTIVE    | full dither, gain=8
//   RAMP_DOWN | gain falls one step per RAMP_LEN accepted samples
module dither_ctrl #(
  parameter int DW       = 16,
  parameter int RAMP_LEN = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cfg_en,
  input  logic [1:0] cfg_shift,
  dither_if.slave    bus,
  output logic [1:0] state,
  output logic [3:0] gain,
  output logic       sat_flag
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [7:0] SCNT_LAST = 8'(RAMP_LEN - 1);
  localparam logic [3:0] GAIN_MAX  = 4'd8;

  state_t        state_q, state_d;
  logic [3:0]    gain_q, gain_d;
  logic [7:0]    scnt_q, scnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          sat_q, sat_d;

  logic              in_ready;
  logic              accept;
  logic              step;
  logic signed [7:0] dith_s;
  logic signed [7:0] gain_s;
  logic signed [7:0] prod;
  logic [7:0]        dterm;
  logic [DW:0]       sum;
  logic              ovf;
  logic [DW-1:0]     sat_data;

  // rstn gating keeps the generator frozen while the block is held in reset
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = rstn && bus.in_valid && in_ready;
  assign step     = accept && (scnt_q == SCNT_LAST);

  assign bus.in_ready  = in_ready;
  assign bus.dith_adv  = accept;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign state         = state_q;
  assign gain          = gain_q;
  assign sat_flag      = sat_q;

  // pre-step gain is used, so a sample accepted on a step edge sees the old gain
  always_comb begin
    dith_s   = {{6{bus.dith_in[1]}}, bus.dith_in};
    gain_s   = {4'b0000, gain_q};
    prod     = dith_s * gain_s;
    dterm    = 8'(prod <<< cfg_shift);
    sum      = {bus.in_data[DW-1], bus.in_data} + {{(DW-7){dterm[7]}}, dterm};
    ovf      = sum[DW] ^ sum[DW-1];
    sat_data = sum[DW-1:0];
    if (ovf) begin
      sat_data = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q | (accept & ovf);
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_data;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    scnt_d  = scnt_q;
    case (state_q)
      IDLE: begin
        gain_d = '0;
        scnt_d = '0;
        if (cfg_en) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!cfg_en) begin
          state_d = RAMP_DOWN;
          scnt_d  = '0;
        end else if (gain_q >= GAIN_MAX) begin
          // re-entered from RAMP_DOWN before any step was taken
          state_d = ACTIVE;
          scnt_d  = '0;
        end else if (step) begin
          scnt_d = '0;
          gain_d = gain_q + 4'd1;
          if (gain_q == GAIN_MAX - 4'd1) state_d = ACTIVE;
        end else if (accept) begin
          scnt_d = scnt_q + 8'd1;
        end
      end
      ACTIVE: begin
        gain_d = GAIN_MAX;
        if (!cfg_en) begin
          state_d = RAMP_DOWN;
          scnt_d  = '0;
        end
      end
      RAMP_DOWN: begin
        if (cfg_en) begin
          state_d = RAMP_UP;
          scnt_d  = '0;
        end else if (gain_q == 4'd0) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else if (step) begin
          scnt_d = '0;
          gain_d = gain_q - 4'd1;
          if (gain_q == 4'd1) state_d = IDLE;
        end else if (accept) begin
          scnt_d = scnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gain_q      <= '0;
      scnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      scnt_q      <= scnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_dither_ctrl.sv
// Randomized bench for dither_ctrl: a mode/gain/accept-count reference model
// plus a scoreboard of expected output samples, with directed scenario checks.
module tb_dither_ctrl;
  localparam int DW       = 16;
  localparam int RAMP_LEN = 16;
  localparam int SMAX     = (1 << (DW - 1)) - 1;
  localparam int SMIN     = -(1 << (DW - 1));
  localparam int M_IDLE = 0, M_UP = 1, M_ACT = 2, M_DOWN = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       cfg_en = 1'b0;
  logic [1:0] cfg_shift = 2'd0;
  logic [1:0] state;
  logic [3:0] gain;
  logic       sat_flag;

  dither_if #(.DW(DW)) bus ();

  dither_ctrl #(.DW(DW), .RAMP_LEN(RAMP_LEN)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cfg_en   (cfg_en),
    .cfg_shift(cfg_shift),
    .bus      (bus),
    .state    (state),
    .gain     (gain),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  int m_mode, m_gain, m_cnt, m_od;
  bit m_ov, m_sat;
  int sb[$];
  int n_cmp = 0, n_err = 0;
  int n_acc = 0;
  int n_adv = 0, n_xfer = 0;

  function automatic int dval(input logic [1:0] d);
    return (d == 2'b01) ? 1 : -1;
  endfunction

  function automatic logic [1:0] rand_dith();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return DW'(SMAX - int'($urandom_range(0, 15)));
      1:       return DW'(SMIN + int'($urandom_range(0, 15)));
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_gain = 0; m_cnt = 0; m_od = 0; m_ov = 0; m_sat = 0;
    sb.delete();
  endtask

  // gain ramp: one step per RAMP_LEN accepted samples, direction from cfg_en
  task automatic model_ramp(input bit acc);
    case (m_mode)
      M_IDLE: if (cfg_en) begin m_mode = M_UP; m_cnt = 0; end
      M_UP: begin
        if (!cfg_en) begin m_mode = M_DOWN; m_cnt = 0; end
        else if (m_gain == 8) begin m_mode = M_ACT; m_cnt = 0; end
        else if (acc) begin
          m_cnt++;
          if (m_cnt == RAMP_LEN) begin
            m_cnt = 0; m_gain++;
            if (m_gain == 8) m_mode = M_ACT;
          end
        end
      end
      M_ACT: if (!cfg_en) begin m_mode = M_DOWN; m_cnt = 0; end
      default: begin
        if (cfg_en) begin m_mode = M_UP; m_cnt = 0; end
        else if (m_gain == 0) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (acc) begin
          m_cnt++;
          if (m_cnt == RAMP_LEN) begin
            m_cnt = 0; m_gain--;
            if (m_gain == 0) m_mode = M_IDLE;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    bit acc, rdy;
    int s, c, e;
    @(negedge clk);
    rdy = !m_ov || bus.out_ready;
    acc = bus.in_valid && rdy;
    n_cmp++;
    if (bus.in_ready !== rdy) begin
      n_err++; $display("FAIL in_ready: got %b want %b", bus.in_ready, rdy);
    end
    n_cmp++;
    if (bus.dith_adv !== acc) begin
      n_err++; $display("FAIL dith_adv: got %b want %b", bus.dith_adv, acc);
    end
    if (bus.dith_adv === 1'b1) n_adv++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) n_xfer++;
    if (m_ov && bus.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++; $display("FAIL scoreboard: got %0d want <no sample pending>", $signed(bus.out_data));
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== DW'(e)) begin
          n_err++; $display("FAIL xfer_data: got %0d want %0d", $signed(bus.out_data), e);
        end
      end
    end
    if (acc) begin
      s = int'($signed(bus.in_data)) + dval(bus.dith_in) * m_gain * (1 << int'(cfg_shift));
      c = (s > SMAX) ? SMAX : (s < SMIN) ? SMIN : s;
      if (c != s) m_sat = 1;
      m_od = c; m_ov = 1;
      sb.push_back(c);
      n_acc++;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 0;
    end
    model_ramp(acc);
    @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 2'(m_mode)) begin n_err++; $display("FAIL state: got %0d want %0d", state, m_mode); end
    n_cmp++;
    if (gain !== 4'(m_gain)) begin n_err++; $display("FAIL gain: got %0d want %0d", gain, m_gain); end
    n_cmp++;
    if (bus.out_valid !== m_ov) begin n_err++; $display("FAIL out_valid: got %b want %b", bus.out_valid, m_ov); end
    n_cmp++;
    if (bus.out_data !== DW'(m_od)) begin
      n_err++; $display("FAIL out_data: got %0d want %0d", $signed(bus.out_data), m_od);
    end
    n_cmp++;
    if (sat_flag !== m_sat) begin n_err++; $display("FAIL sat_flag: got %b want %b", sat_flag, m_sat); end
  endtask

  task automatic do_reset();
    rstn = 1'b0; bus.in_valid = 1'b0; cfg_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.in_data = 16'd5; bus.dith_in = 2'b01;
    #1 rstn = 1'b0;
    #2;
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (gain !== 4'd0) begin n_err++; $display("FAIL rst_gain: got %0d want 0", gain); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", bus.out_data); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b want 0", sat_flag); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.dith_adv !== 1'b0) begin n_err++; $display("FAIL rst_dith_adv: got %b want 0", bus.dith_adv); end
    do_reset();
  endtask

  task automatic test_passthrough();
    int adv0;
    cfg_en = 1'b0; cfg_shift = 2'($urandom_range(0, 3));
    bus.in_data = 16'd100; bus.dith_in = 2'b01; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    adv0 = n_adv;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd100) begin
        n_err++; $display("FAIL pass_data: got %0d/%b want 100/1", bus.out_data, bus.out_valid);
      end
    end
    n_cmp++;
    if (n_adv - adv0 != 16) begin n_err++; $display("FAIL pass_adv_count: got %0d want 16", n_adv - adv0); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_ramp_up();
    int start, guard;
    bit seen127;
    cfg_en = 1'b1; cfg_shift = 2'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    start = n_acc; guard = 0; seen127 = 0;
    while (n_acc - start < 128 && guard < 1000) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = rand_data();
      bus.dith_in  = rand_dith();
      tick();
      guard++;
      if (n_acc - start == 127 && !seen127) begin
        seen127 = 1;
        n_cmp++;
        if (gain !== 4'd7 || state !== 2'd1) begin
          n_err++; $display("FAIL ramp_127: got gain %0d state %0d want 7/1", gain, state);
        end
      end
    end
    if (guard >= 1000) begin n_cmp++; n_err++; $display("FAIL ramp_up_timeout: got %0d accepts want 128", n_acc - start); end
    n_cmp++;
    if (gain !== 4'd8 || state !== 2'd2) begin
      n_err++; $display("FAIL ramp_128: got gain %0d state %0d want 8/2", gain, state);
    end
    bus.in_valid = 1'b1; bus.in_data = '0; bus.dith_in = 2'b11;
    tick();
    n_cmp++;
    if (bus.out_data !== 16'hFFF8) begin n_err++; $display("FAIL active_minus8: got %0d want -8", $signed(bus.out_data)); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    cfg_shift = 2'd3; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.in_data = 16'sd32760; bus.dith_in = 2'b01;
    tick();
    n_cmp++;
    if (bus.out_data !== 16'h7FFF || sat_flag !== 1'b1) begin
      n_err++; $display("FAIL sat_hi: got %0d sat %b want 32767 sat 1", $signed(bus.out_data), sat_flag);
    end
    bus.in_data = 16'h8000; bus.dith_in = 2'b11;
    tick();
    n_cmp++;
    if (bus.out_data !== 16'h8000) begin n_err++; $display("FAIL sat_lo: got %0d want -32768", $signed(bus.out_data)); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int hold, adv0, acc0, xfer0;
    cfg_shift = 2'($urandom_range(0, 3));
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = rand_data(); bus.dith_in = rand_dith();
    acc0 = n_adv; xfer0 = n_xfer;
    tick();
    hold = m_od;
    bus.out_ready = 1'b0;
    adv0 = n_adv;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = rand_data(); bus.dith_in = rand_dith();
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== DW'(hold)) begin
        n_err++; $display("FAIL stall_hold: got rdy %b data %0d want rdy 0 data %0d", bus.in_ready, $signed(bus.out_data), hold);
      end
    end
    n_cmp++;
    if (n_adv != adv0) begin n_err++; $display("FAIL stall_adv: got %0d pulses want 0", n_adv - adv0); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = rand_data(); bus.dith_in = rand_dith();
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (n_adv - acc0 != n_xfer - xfer0) begin
      n_err++; $display("FAIL stall_conserve: got %0d out want %0d in", n_xfer - xfer0, n_adv - acc0);
    end
  endtask

  task automatic run_accepts(input int n, input int chk_at, input int chk_gain, input int chk_state);
    int start, guard;
    start = n_acc; guard = 0;
    while (n_acc - start < n && guard < 2000) begin
      bus.in_valid = 1'b1; bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data = rand_data(); bus.dith_in = rand_dith();
      tick();
      guard++;
      if (n_acc - start == chk_at && bus.dith_adv === 1'b0 && m_cnt == RAMP_LEN - 1) begin
        n_cmp++;
        if (gain !== 4'(chk_gain) || state !== 2'(chk_state)) begin
          n_err++; $display("FAIL ramp_pre: got gain %0d state %0d want %0d/%0d", gain, state, chk_gain, chk_state);
        end
      end
    end
    if (guard >= 2000) begin n_cmp++; n_err++; $display("FAIL accept_timeout: got %0d want %0d", n_acc - start, n); end
  endtask

  task automatic test_ramp_down();
    do_reset();
    cfg_shift = 2'($urandom_range(0, 3)); cfg_en = 1'b1;
    tick();
    run_accepts(80, 79, 4, 1);
    n_cmp++;
    if (gain !== 4'd5 || state !== 2'd1) begin n_err++; $display("FAIL up_to5: got gain %0d state %0d want 5/1", gain, state); end
    cfg_en = 1'b0; bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (gain !== 4'd5 || state !== 2'd3) begin n_err++; $display("FAIL drop_en: got gain %0d state %0d want 5/3", gain, state); end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (gain !== 4'd5 || state !== 2'd3) begin n_err++; $display("FAIL idle_hold: got gain %0d state %0d want 5/3", gain, state); end
    run_accepts(80, 79, 1, 3);
    n_cmp++;
    if (gain !== 4'd0 || state !== 2'd0) begin n_err++; $display("FAIL down_idle: got gain %0d state %0d want 0/0", gain, state); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int guard;
    cfg_en = 1'b1; guard = 0;
    while (m_mode != M_ACT && guard < 2000) begin
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = rand_data(); bus.dith_in = rand_dith();
      tick();
      guard++;
    end
    if (guard >= 2000) begin n_cmp++; n_err++; $display("FAIL reach_active: got state %0d want 2", state); end
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || state !== 2'd2) begin
      n_err++; $display("FAIL pre_reset: got valid %b state %0d want 1/2", bus.out_valid, state);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (state !== 2'd0 || gain !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got st %0d g %0d v %b d %0d s %b want 0 0 0 0 0", state, gain, bus.out_valid, bus.out_data, sat_flag);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.dith_adv !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_hs: got rdy %b adv %b want 1/0", bus.in_ready, bus.dith_adv);
    end
    bus.in_valid = 1'b0; cfg_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg_en = !cfg_en;
      cfg_shift     = 2'($urandom_range(0, 3));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_data   = rand_data();
      bus.dith_in   = rand_dith();
      tick();
    end
  endtask

  initial begin
    model_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_data = '0; bus.dith_in = 2'b01;
    test_reset();
    test_passthrough();
    test_ramp_up();
    test_saturation();
    test_backpressure();
    test_ramp_down();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
